// File: rtl/chunked_add_sub_pkg.sv
// chunked_add_sub_pkg
//   Shared definitions for the chunked adder/subtractor:
//   - state_t     : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE), 2 bits
//   - calc_num_chunks : number of CHUNK_SIZE slices in a DATA_SIZE_PARAMETER word
//   - calc_idx_width  : width of the chunk index register (clog2, minimum 1)
package chunked_add_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned calc_num_chunks(input int unsigned data_size,
                                                   input int unsigned chunk_size);
      return data_size / chunk_size;
   endfunction

   function automatic int unsigned calc_idx_width(input int unsigned num_chunks);
      return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
   endfunction

endpackage

// File: rtl/chunked_add_sub_add_chunk.sv
// fullAdder
//   One-bit full adder.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// add_chunk
//   Combinational CHUNK_SIZE-bit ripple adder built from fullAdder cells.
//   cin     : carry into bit 0
//   a, b    : chunk operands
//   sum     : chunk sum
//   cout    : carry out of the top bit
//   msb_cin : carry into the top bit (used for signed overflow on the last chunk)
module add_chunk #(
   parameter int CHUNK_SIZE = 2
) (
   input  logic                  cin,
   input  logic [CHUNK_SIZE-1:0] a,
   input  logic [CHUNK_SIZE-1:0] b,
   output logic [CHUNK_SIZE-1:0] sum,
   output logic                  cout,
   output logic                  msb_cin
);

   logic [CHUNK_SIZE:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK_SIZE; i++) begin : g_bit
      fullAdder u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (c[i]),
         .sum (sum[i]),
         .cout(c[i+1])
      );
   end

   assign cout    = c[CHUNK_SIZE];
   assign msb_cin = c[CHUNK_SIZE-1];

endmodule

// File: rtl/chunked_add_sub.sv
// chunked_add_sub
//   Multi-cycle adder/subtractor processing CHUNK_SIZE bits per clock, LSB
//   chunk first, through a single reused add_chunk instance.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request, sampled only in IDLE or DONE
//   sub        : 0 = A+B+cin, 1 = A-B-cin
//   accumulate : 1 = operand A is the current sum_out (dataA ignored)
//   cin        : carry-in (add) or borrow-in (sub)
//   dataA/B    : operands
//   busy       : high while computing
//   done       : one-cycle pulse, results valid from this cycle
//   sum_out    : registered result, held until the next completion
//   carry      : raw carry out of the MSB (sub: 1 = no borrow)
//   overflow   : signed overflow (carry into MSB xor carry out of MSB)
//   zero       : sum_out == 0
module chunked_add_sub
   import chunked_add_sub_pkg::*;
#(
   parameter int DATA_SIZE_PARAMETER = 8,
   parameter int CHUNK_SIZE          = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           sub,
   input  logic                           accumulate,
   input  logic                           cin,
   input  logic [DATA_SIZE_PARAMETER-1:0] dataA,
   input  logic [DATA_SIZE_PARAMETER-1:0] dataB,
   output logic                           busy,
   output logic                           done,
   output logic [DATA_SIZE_PARAMETER-1:0] sum_out,
   output logic                           carry,
   output logic                           overflow,
   output logic                           zero
);

   localparam int unsigned NUM_CHUNKS = calc_num_chunks(DATA_SIZE_PARAMETER, CHUNK_SIZE);
   localparam int unsigned IDX_W      = calc_idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_CHUNKS - 1);

   state_t state, state_next;

   logic [DATA_SIZE_PARAMETER-1:0] op_a, op_b, res, res_next;
   logic [IDX_W-1:0]               k;
   logic                           carry_r;
   logic                           load, step, last;

   logic [CHUNK_SIZE-1:0] chunk_sum;
   logic                  chunk_cout, chunk_msb_cin;

   // Operands are shifted right each RUN cycle so the active chunk is always
   // at the bottom; the result enters from the top so that after NUM_CHUNKS
   // shifts the first chunk lands in the LSB position.
   logic [DATA_SIZE_PARAMETER+CHUNK_SIZE-1:0] res_cat;

   add_chunk #(.CHUNK_SIZE(CHUNK_SIZE)) u_add_chunk (
      .cin    (carry_r),
      .a      (op_a[CHUNK_SIZE-1:0]),
      .b      (op_b[CHUNK_SIZE-1:0]),
      .sum    (chunk_sum),
      .cout   (chunk_cout),
      .msb_cin(chunk_msb_cin)
   );

   always_comb begin
      res_cat  = {chunk_sum, res};
      res_next = res_cat[DATA_SIZE_PARAMETER+CHUNK_SIZE-1:CHUNK_SIZE];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = (k == K_LAST);
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         op_a     <= '0;
         op_b     <= '0;
         res      <= '0;
         k        <= '0;
         carry_r  <= 1'b0;
         sum_out  <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (load) begin
         op_a    <= accumulate ? sum_out : dataA;
         op_b    <= sub ? ~dataB : dataB;
         carry_r <= sub ? ~cin : cin;
         res     <= '0;
         k       <= '0;
      end else if (step) begin
         op_a    <= op_a >> CHUNK_SIZE;
         op_b    <= op_b >> CHUNK_SIZE;
         res     <= res_next;
         carry_r <= chunk_cout;
         k       <= k + 1'b1;
         if (last) begin
            sum_out  <= res_next;
            carry    <= chunk_cout;
            overflow <= chunk_msb_cin ^ chunk_cout;
            zero     <= (res_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_chunked_add_sub.sv
module tb_chunked_add_sub;

   localparam int D      = 8;
   localparam int C      = 2;
   localparam int N      = D / C;
   localparam int RST_AT = (N >= 3) ? 2 : 0;

   logic         clk = 1'b0;
   logic         reset, start, sub, accumulate, cin;
   logic [D-1:0] dataA, dataB;
   logic         busy, done, carry, overflow, zero;
   logic [D-1:0] sum_out;

   always #5 clk = ~clk;

   chunked_add_sub #(.DATA_SIZE_PARAMETER(D), .CHUNK_SIZE(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sub       (sub),
      .accumulate(accumulate),
      .cin       (cin),
      .dataA     (dataA),
      .dataB     (dataB),
      .busy      (busy),
      .done      (done),
      .sum_out   (sum_out),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      logic       ci;
      logic [7:0] e_sum;
      logic       e_c;
      logic       e_ov;
      logic       e_z;
   } vec_t;

   vec_t vt[11];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives a request, steps past the sampling edge, then scrambles the
   // request inputs to show they are not used after sampling.
   task automatic launch(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic ci, input logic acc);
      dataA = a; dataB = b; sub = s; cin = ci; accumulate = acc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dataA = ~a; dataB = ~b; sub = ~s; cin = ~ci; accumulate = ~acc;
   endtask

   // Waits (bounded) for done, checking latency, busy duration and that
   // the visible outputs stay frozen while computing.
   task automatic wait_done(input string tag);
      int lat = 0;
      int busy_cnt = 0;
      logic [D+2:0] held;
      held = {sum_out, carry, overflow, zero};
      while (!done && lat < 4 * N + 8) begin
         if (busy) busy_cnt++;
         chk({tag, "_held"}, {sum_out, carry, overflow, zero}, held);
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         n_err++;
         $display("FAIL %s_timeout: got no done after %0d cycles, expected done after %0d", tag, lat, N);
      end
      chk({tag, "_latency"}, lat, N);
      chk({tag, "_busy_cycles"}, busy_cnt, N);
      chk({tag, "_busy_at_done"}, busy, 0);
   endtask

   task automatic check_result(input string tag, input logic [7:0] e_sum,
                               input logic e_c, input logic e_ov, input logic e_z);
      n_vec++;
      chk({tag, "_sum"}, sum_out, e_sum);
      chk({tag, "_carry"}, carry, e_c);
      chk({tag, "_overflow"}, overflow, e_ov);
      chk({tag, "_zero"}, zero, e_z);
   endtask

   task automatic check_idle(input string tag, input logic [7:0] e_sum);
      @(posedge clk); #1;
      chk({tag, "_idle_done"}, done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_sum"}, sum_out, e_sum);
   endtask

   initial begin
      logic [7:0] model_sum;
      int ndone, first_done;
      logic [7:0] sum_at_done;

      vt[0]  = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0};
      vt[1]  = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vt[4]  = '{8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vt[6]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{8'h12, 8'h34, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0, 1'b0};
      vt[10] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

      reset = 1'b1; start = 1'b0; sub = 1'b0; accumulate = 1'b0; cin = 1'b0;
      dataA = '0; dataB = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, sum_out, carry, overflow, zero}, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", {busy, done}, 2'b00);

      // Table-driven vectors, each followed by a return to IDLE.
      for (int i = 0; i < 11; i++) begin
         launch(vt[i].a, vt[i].b, vt[i].s, vt[i].ci, 1'b0);
         wait_done($sformatf("vec%0d", i));
         check_result($sformatf("vec%0d", i), vt[i].e_sum, vt[i].e_c, vt[i].e_ov, vt[i].e_z);
         check_idle($sformatf("vec%0d", i), vt[i].e_sum);
      end

      // Back-to-back accumulate chain launched from the DONE cycle.
      launch(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      wait_done("b2b0");
      check_result("b2b0", 8'h00, 1'b1, 1'b0, 1'b1);
      launch(8'hAA, 8'h0F, 1'b0, 1'b0, 1'b1);
      chk("b2b1_busy", busy, 1);
      chk("b2b1_done", done, 0);
      wait_done("b2b1");
      check_result("b2b1", 8'h0F, 1'b0, 1'b0, 1'b0);
      launch(8'h55, 8'h10, 1'b1, 1'b0, 1'b1);
      wait_done("b2b2");
      check_result("b2b2", 8'hFF, 1'b0, 1'b0, 1'b0);
      check_idle("b2b2", 8'hFF);

      // start pulsed mid-RUN must be ignored.
      launch(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
      ndone = 0; first_done = -1; sum_at_done = '0;
      for (int cyc = 0; cyc < N + 4; cyc++) begin
         if (cyc == 1 && busy) begin
            dataA = 8'h11; dataB = 8'h22; sub = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first_done < 0) begin
               first_done  = cyc + 1;
               sum_at_done = sum_out;
            end
         end
      end
      n_vec++;
      chk("ignored_start_done_pulses", ndone, 1);
      chk("ignored_start_latency", first_done, N);
      chk("ignored_start_sum", sum_at_done, 8'h8D);
      chk("ignored_start_final_busy", busy, 0);

      // Reset in the middle of an operation.
      launch(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
      repeat (RST_AT) begin
         @(posedge clk); #1;
      end
      chk("midreset_still_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_vec++;
      chk("midreset_outputs", {busy, done, sum_out, carry, overflow, zero}, '0);
      ndone = 0;
      repeat (N + 2) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("midreset_no_done", ndone, 0);
      launch(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
      wait_done("post_reset");
      check_result("post_reset", 8'h8D, 1'b0, 1'b1, 1'b0);
      model_sum = 8'h8D;

      // Random sweep against an independent reference model.
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] a, b, opa, bb, r;
         logic       s, ci, acc, cc, c, ov;
         a   = 8'($urandom);
         b   = 8'($urandom);
         s   = 1'($urandom);
         ci  = 1'($urandom);
         acc = ($urandom_range(0, 3) == 0);
         opa = acc ? model_sum : a;
         bb  = s ? ~b : b;
         cc  = s ? ~ci : ci;
         {c, r} = {1'b0, opa} + {1'b0, bb} + {8'h00, cc};
         ov  = (opa[7] == bb[7]) && (r[7] != opa[7]);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
         launch(a, b, s, ci, acc);
         wait_done($sformatf("rnd%0d", i));
         check_result($sformatf("rnd%0d", i), r, c, ov, (r == 8'h00));
         model_sum = r;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
